ahb_cmd_manager: RTL
====================

# ahb_cmd_manager

AHB3-Lite manager (initiator) that turns a simple valid/ready command stream into single, non-burst AHB transfers and returns one response per command. It is the initiator counterpart to the subordinates on the data interconnect (timer, UART controller, RAMs), so on-chip agents such as a debug or loader engine can access the address map without a core. It connects upstream of the interconnect, alongside the core's data port, via an external arbiter or a dedicated interconnect. Address and data phases are pipelined, and the two-cycle ERROR response is handled by suspending and re-issuing the pending transfer.

## Interface
- HPROT, 4'b0011: constant value driven on s_hprot_o.
- s_clk_i  in  1  system clock; all state on rising edge.
- s_resetn_i  in  1  reset, asynchronous, active-low.
- s_cmd_valid_i  in  1  command valid; cmd fields must stay stable until accepted.
- s_cmd_ready_o  out  1  command accepted on the edge where valid & ready.
- s_cmd_addr_i  in  32  byte address, aligned to size.
- s_cmd_wdata_i  in  32  write data, lane-positioned as on HWDATA.
- s_cmd_write_i  in  1  1 = write, 0 = read.
- s_cmd_size_i  in  3  HSIZE value, 0..2 only.
- s_rsp_valid_o  out  1  one-cycle pulse per completed command, in order.
- s_rsp_err_o  out  1  transfer ended with ERROR; valid with s_rsp_valid_o.
- s_rsp_rdata_o  out  32  read data; 0 for writes.
- s_busy_o  out  1  any transfer in address phase, data phase or response stage.
- s_haddr_o  out  32, s_htrans_o  out  2, s_hwrite_o  out  1, s_hsize_o  out  3: registered address phase.
- s_hburst_o  out  3  constant 3'b000 (SINGLE).
- s_hmastlock_o  out  1  constant 0.
- s_hprot_o  out  4  constant HPROT.
- s_hwdata_o  out  32  registered data-phase write data.
- s_hrdata_i  in  32, s_hready_i  in  1, s_hresp_i  in  1: from the interconnect.

## Operation
- The address slot (aval, addr, write, size, wdata) holds one accepted command that is presented on the bus.
- The data slot (dval, dwrite, hwdata) tracks the transfer currently in its data phase.
- err_first = dval & s_hresp_i & ~s_hready_i marks the first ERROR cycle.
- susp_q is a flop. It is set on the edge where err_first is true and cleared on the next edge.
- s_htrans_o = NONSEQ (2'b10) when aval & ~susp_q, otherwise IDLE (2'b00). SEQ and BUSY are never driven.
- adv = aval & s_hready_i & ~err_first & ~susp_q. The address phase completes only when adv is true.
- s_cmd_ready_o = ~aval | adv.
- On accept, the address slot loads the command fields and aval is set.
- On adv without a new accept, aval is cleared.
- On adv, the data slot loads from the address slot and dval is set.
- On s_hready_i & dval without adv, dval is cleared.
- Response stage, registered: s_rsp_valid_o is set on the edge where dval & s_hready_i.
  - s_rsp_err_o takes s_hresp_i at that edge.
  - s_rsp_rdata_o takes s_hrdata_i for reads and 0 for writes.
  - There is no response backpressure.
- ERROR handling:
  - Cycle E1 (hresp=1, hready=0): the pending address phase is not sampled.
  - Cycle E2: susp_q forces IDLE and hready=1 completes the errored transfer.
  - Cycle E3: the pending command is re-presented as NONSEQ with unchanged fields.
  - The pending command is never dropped or reported as failed.
- A single-cycle hresp=1 with hready=1 is a protocol violation. It is reported as err with no suspend.
- Misaligned addresses and size > 2 are illegal inputs; the bench asserts against them.
- s_busy_o = aval | dval | s_rsp_valid_o.

## Timing
- Reset values:
  - s_htrans_o = IDLE; s_haddr_o, s_hwrite_o, s_hsize_o, s_hwdata_o = 0.
  - s_cmd_ready_o = 1.
  - s_rsp_valid_o, s_rsp_err_o, s_rsp_rdata_o = 0.
  - s_busy_o = 0; susp_q, aval, dval = 0.
- Reset mid-transfer: the bus returns to IDLE immediately (asynchronously). In-flight commands are lost and produce no response.
- Zero-wait latency:
  - Accept at edge T; NONSEQ during cycle T+1; data phase during T+2.
  - s_rsp_valid_o high during T+3. Latency from accept to response is 3 cycles.
- Throughput: back-to-back commands with zero-wait subordinates give one transfer per cycle, with continuous NONSEQ.
- Wait states: each cycle of hready=0 in the data phase delays that response and the next address phase by one cycle. Address-phase outputs hold stable.
- ERROR costs exactly one extra IDLE cycle (E2) before the re-issued transfer.

## Test plan
- Single write then read, zero-wait RAM:
  - Write 0x10000004 <= 0xDEADBEEF, then read 0x10000004.
  - Required: NONSEQ one cycle after each accept.
  - Required: responses 3 cycles after each accept; read returns rdata=0xDEADBEEF, err=0.
- Four back-to-back word reads, 0x10000000..0x1000000C:
  - Required: htrans=NONSEQ for 4 consecutive cycles and 4 consecutive rsp pulses.
  - Required: haddr increments by 4.
- Wait states:
  - Subordinate inserts 2 cycles of hready=0 on the first of two reads.
  - Required: the second address holds on haddr for those cycles; s_cmd_ready_o=0 while the slot is full.
  - Required: responses arrive 2 cycles late, in order.
- ERROR with a pipelined command:
  - Write to 0x00000000 (read-only) returns a two-cycle ERROR while a read of 0x10000000 is pending.
  - Required: htrans=IDLE in E2 and rsp err=1 for the write.
  - Required: the read is re-issued as NONSEQ in E3 and completes with err=0.
- Reset mid-operation:
  - Assert s_resetn_i low during a wait-stated data phase.
  - Required: htrans=IDLE and s_busy_o=0 immediately.
  - Required: no s_rsp_valid_o pulse; after release, the first command completes normally.

Source files
------------

// File: rtl/ahb_cmd_manager_if.sv
// Bundle of the command/response stream and the AHB3-Lite manager bus
// for ahb_cmd_manager. The master modport is the manager's view.
interface ahb_cmd_manager_if;
    logic        s_cmd_valid_i;
    logic        s_cmd_ready_o;
    logic [31:0] s_cmd_addr_i;
    logic [31:0] s_cmd_wdata_i;
    logic        s_cmd_write_i;
    logic [2:0]  s_cmd_size_i;

    logic        s_rsp_valid_o;
    logic        s_rsp_err_o;
    logic [31:0] s_rsp_rdata_o;
    logic        s_busy_o;

    logic [31:0] s_haddr_o;
    logic [1:0]  s_htrans_o;
    logic        s_hwrite_o;
    logic [2:0]  s_hsize_o;
    logic [2:0]  s_hburst_o;
    logic        s_hmastlock_o;
    logic [3:0]  s_hprot_o;
    logic [31:0] s_hwdata_o;
    logic [31:0] s_hrdata_i;
    logic        s_hready_i;
    logic        s_hresp_i;

    modport master (
        input  s_cmd_valid_i, s_cmd_addr_i, s_cmd_wdata_i, s_cmd_write_i, s_cmd_size_i,
        input  s_hrdata_i, s_hready_i, s_hresp_i,
        output s_cmd_ready_o, s_rsp_valid_o, s_rsp_err_o, s_rsp_rdata_o, s_busy_o,
        output s_haddr_o, s_htrans_o, s_hwrite_o, s_hsize_o, s_hburst_o,
        output s_hmastlock_o, s_hprot_o, s_hwdata_o
    );

    modport slave (
        output s_cmd_valid_i, s_cmd_addr_i, s_cmd_wdata_i, s_cmd_write_i, s_cmd_size_i,
        output s_hrdata_i, s_hready_i, s_hresp_i,
        input  s_cmd_ready_o, s_rsp_valid_o, s_rsp_err_o, s_rsp_rdata_o, s_busy_o,
        input  s_haddr_o, s_htrans_o, s_hwrite_o, s_hsize_o, s_hburst_o,
        input  s_hmastlock_o, s_hprot_o, s_hwdata_o
    );
endinterface

// File: rtl/ahb_cmd_manager.sv
// AHB3-Lite manager: valid/ready commands become single NONSEQ transfers with
// pipelined address/data phases; a two-cycle ERROR suspends and re-issues the pending command.
module ahb_cmd_manager #(
    parameter logic [3:0] HPROT = 4'b0011
) (
    input  logic               s_clk_i,
    input  logic               s_resetn_i,
    ahb_cmd_manager_if.master  bus
);
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    logic        vld_p0;
    logic [31:0] addr_p0;
    logic [31:0] wdata_p0;
    logic        write_p0;
    logic [2:0]  size_p0;

    logic        vld_p1;
    logic        write_p1;
    logic [31:0] hwdata_p1;

    logic        vld_p2;
    logic        err_p2;
    logic [31:0] rdata_p2;

    logic        susp_q;
    logic        err_first;
    logic        adv;
    logic        ready;
    logic        accept;
    logic        dp_done;

    assign err_first = vld_p1 & bus.s_hresp_i & ~bus.s_hready_i;
    assign adv       = vld_p0 & bus.s_hready_i & ~err_first & ~susp_q;
    assign ready     = ~vld_p0 | adv;
    assign accept    = bus.s_cmd_valid_i & ready;
    assign dp_done   = vld_p1 & bus.s_hready_i;

    // Holds off the address phase for the IDLE cycle that ends an ERROR response
    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            susp_q <= 1'b0;
        end else begin
            susp_q <= err_first;
        end
    end

    // Stage p0: address slot, presented on the bus
    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            vld_p0   <= 1'b0;
            addr_p0  <= 32'd0;
            wdata_p0 <= 32'd0;
            write_p0 <= 1'b0;
            size_p0  <= 3'd0;
        end else if (accept) begin
            vld_p0   <= 1'b1;
            addr_p0  <= bus.s_cmd_addr_i;
            wdata_p0 <= bus.s_cmd_wdata_i;
            write_p0 <= bus.s_cmd_write_i;
            size_p0  <= bus.s_cmd_size_i;
        end else if (adv) begin
            vld_p0   <= 1'b0;
        end
    end

    // Stage p1: data slot, transfer in its data phase
    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            vld_p1    <= 1'b0;
            write_p1  <= 1'b0;
            hwdata_p1 <= 32'd0;
        end else if (adv) begin
            vld_p1    <= 1'b1;
            write_p1  <= write_p0;
            hwdata_p1 <= wdata_p0;
        end else if (dp_done) begin
            vld_p1    <= 1'b0;
        end
    end

    // Stage p2: registered response pulse, no backpressure
    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            vld_p2   <= 1'b0;
            err_p2   <= 1'b0;
            rdata_p2 <= 32'd0;
        end else begin
            vld_p2   <= dp_done;
            err_p2   <= dp_done & bus.s_hresp_i;
            rdata_p2 <= (dp_done && !write_p1) ? bus.s_hrdata_i : 32'd0;
        end
    end

    assign bus.s_cmd_ready_o = ready;
    assign bus.s_rsp_valid_o = vld_p2;
    assign bus.s_rsp_err_o   = err_p2;
    assign bus.s_rsp_rdata_o = rdata_p2;
    assign bus.s_busy_o      = vld_p0 | vld_p1 | vld_p2;

    assign bus.s_htrans_o    = (vld_p0 && !susp_q) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign bus.s_haddr_o     = addr_p0;
    assign bus.s_hwrite_o    = write_p0;
    assign bus.s_hsize_o     = size_p0;
    assign bus.s_hwdata_o    = hwdata_p1;
    assign bus.s_hburst_o    = 3'b000;
    assign bus.s_hmastlock_o = 1'b0;
    assign bus.s_hprot_o     = HPROT;
endmodule
